// File: rtl/io_memory_pkg.sv
// -----------------------------------------------------------------------------
// io_memory_pkg
// Shared constants and types for the memory-mapped I/O block:
//   MEM_SIZE     - number of byte locations in the I/O space
//   ADDR_W       - address bits actually decoded
//   DATA_W       - width of the shared data-return bus
//   intr_state_t - two-state interrupt generator state
// -----------------------------------------------------------------------------
package io_memory_pkg;

    localparam int MEM_SIZE = 4096;
    localparam int ADDR_W   = $clog2(MEM_SIZE);
    localparam int DATA_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } intr_state_t;

endpackage : io_memory_pkg

// File: rtl/io_intr_gen.sv
// -----------------------------------------------------------------------------
// io_intr_gen
// Periodic interrupt source. Counts INTR_PERIOD clocks in IDLE, then sits in
// PEND (request asserted) until the CPU acknowledges, then restarts counting.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   int_ack  in   interrupt acknowledge, only honoured while in PEND
//   state    out  current generator state; PEND means a request is pending
// -----------------------------------------------------------------------------
module io_intr_gen
    import io_memory_pkg::*;
#(
    parameter int INTR_PERIOD = 200,
    parameter bit INTR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_ack,
    output intr_state_t state
);

    localparam int CNT_W = ($clog2(INTR_PERIOD) < 1) ? 1 : $clog2(INTR_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTR_PERIOD - 1);

    intr_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // State register: state and counter both clear asynchronously, which also
    // discards any pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. An ack seen in IDLE (including on the very edge that
    // raises the request) is ignored because only PEND looks at int_ack.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (INTR_ENABLE && (cnt == CNT_LAST)) state_next = PEND;
            PEND:    if (int_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter datapath: runs in IDLE, holds in PEND, restarts from 0 on the
    // IDLE->PEND transition and on acknowledge.
    always_comb begin
        cnt_next = cnt;
        if (!INTR_ENABLE) begin
            cnt_next = '0;
        end else if (state == IDLE) begin
            cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end else if (int_ack) begin
            cnt_next = '0;
        end
    end

endmodule : io_intr_gen

// File: rtl/io_memory.sv
// -----------------------------------------------------------------------------
// io_memory
// 4 KB byte-addressable, big-endian memory-mapped I/O space with a periodic
// interrupt source.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset (interrupt logic only)
//   cs       in   chip select
//   wr       in   write enable, qualified by cs
//   rd       in   read enable, qualified by cs
//   int_ack  in   interrupt acknowledge from the CPU
//   Addr     in   byte address, only Addr[11:0] decoded
//   IO_In    in   write data
//   int_r    out  interrupt request to the CPU
//   IO_Out   out  read data on the shared return bus; released (z) unless
//                 cs & rd so the data memory can drive the same bus
//
// Handshake: there is no valid/ready pair. A read is combinational while
// cs & rd are high; a write commits on the rising edge where cs & wr are high.
// With rd and wr together the bus shows pre-edge contents.
// -----------------------------------------------------------------------------
module io_memory
  import io_memory_pkg::*;
#(
  parameter int INTR_PERIOD = 200,
  parameter bit INTR_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic              int_ack,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] IO_In,
  output logic              int_r,
  output tri   [DATA_W-1:0] IO_Out
);

  // Not cleared by reset; a bench may preload it directly.
  reg [7:0] Mem [0:MEM_SIZE-1];

  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] rd_data;
  logic              unused_addr_hi;
  intr_state_t       intr_state;

  assign unused_addr_hi = ^Addr[DATA_W-1:ADDR_W];

  // 12-bit adds wrap naturally at the top of the space.
  assign a0 = Addr[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (cs && wr) begin
      Mem[a0] <= IO_In[31:24];
      Mem[a1] <= IO_In[23:16];
      Mem[a2] <= IO_In[15:8];
      Mem[a3] <= IO_In[7:0];
    end
  end

  assign rd_data = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
  assign IO_Out  = (cs && rd) ? rd_data : {DATA_W{1'bz}};

  io_intr_gen #(
    .INTR_PERIOD (INTR_PERIOD),
    .INTR_ENABLE (INTR_ENABLE)
  ) u_intr_gen (
    .clk     (clk),
    .reset   (reset),
    .int_ack (int_ack),
    .state   (intr_state)
  );

  // The state is a flop, so the request is a registered signal.
  assign int_r = (intr_state == PEND);

endmodule : io_memory

// File: tb/tb_io_memory.sv
module tb_io_memory;

    localparam int PERIOD = 10;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        cs      = 1'b0;
    logic        wr      = 1'b0;
    logic        rd      = 1'b0;
    logic        int_ack = 1'b0;
    logic [31:0] Addr    = '0;
    logic [31:0] IO_In   = '0;
    logic        int_r;

    // Shared return bus: a second driver stands in for the data memory.
    tri   [31:0] io_bus;
    logic        other_en  = 1'b0;
    logic [31:0] other_val = '0;
    assign io_bus = other_en ? other_val : 32'hz;

    int total = 0;
    int bad   = 0;

    io_memory #(
        .INTR_PERIOD (PERIOD),
        .INTR_ENABLE (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .wr      (wr),
        .rd      (rd),
        .int_ack (int_ack),
        .Addr    (Addr),
        .IO_In   (IO_In),
        .int_r   (int_r),
        .IO_Out  (io_bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference models ----------------
    // Interrupt: the request appears PERIOD edges after the last restart
    // (reset release or an honoured ack) and stays until acked.
    int m_edges   = 0;
    int m_restart = 0;
    bit m_pend    = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend    = 1'b0;
            m_edges   = 0;
            m_restart = 0;
        end else begin
            m_edges = m_edges + 1;
            if (m_pend) begin
                if (int_ack) begin
                    m_pend    = 1'b0;
                    m_restart = m_edges;
                end
            end else if (m_edges - m_restart == PERIOD) begin
                m_pend = 1'b1;
            end
        end
    end

    // Byte store model.
    logic [7:0] m_mem [0:4095];

    function automatic logic [31:0] model_word(input int a);
        return {m_mem[a % 4096], m_mem[(a + 1) % 4096],
                m_mem[(a + 2) % 4096], m_mem[(a + 3) % 4096]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        int a;
        cs = 1'b1; wr = 1'b1; rd = 1'b0; Addr = addr; IO_In = data;
        step();
        cs = 1'b0; wr = 1'b0;
        a = int'(addr[11:0]);
        for (int k = 0; k < 4; k++) m_mem[(a + k) % 4096] = data[31 - 8*k -: 8];
    endtask

    // Cycles until int_r is seen high, or -1 after a bounded wait.
    task automatic cycles_to_rise(output int n);
        n = -1;
        for (int i = 1; i <= 4 * PERIOD; i++) begin
            step();
            if (int_r === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (int_r !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: int_r=%b expected 0", int_r);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= PERIOD; i++) begin
            step();
            total++;
            if (int_r !== (i == PERIOD)) begin
                bad++;
                $display("FAIL reset_first_rise: edge %0d int_r=%b expected %b", i, int_r, i == PERIOD);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] exp_bytes;
        bus_write(32'h0000_03F0, 32'hDEAD_BEEF);
        exp_bytes = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (dut.Mem[12'h3F0 + k] !== exp_bytes[31 - 8*k -: 8]) begin
                bad++;
                $display("FAIL write_byte: Mem[%h]=%h expected %h", 12'h3F0 + k, dut.Mem[12'h3F0 + k], exp_bytes[31 - 8*k -: 8]);
            end
        end
        cs = 1'b1; rd = 1'b1; Addr = 32'h0000_03F0;
        #1;
        total++;
        if (io_bus !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL read_word: got %h expected DEADBEEF", io_bus);
        end
        // Read and write together: pre-edge data, then new data after edge.
        wr = 1'b1; IO_In = 32'hCAFE_F00D;
        #1;
        total++;
        if (io_bus !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rdwr_pre_edge: got %h expected DEADBEEF", io_bus);
        end
        step();
        wr = 1'b0;
        for (int k = 0; k < 4; k++) m_mem[12'h3F0 + k] = 8'(32'hCAFE_F00D >> (24 - 8*k));
        #1;
        total++;
        if (io_bus !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL rdwr_post_edge: got %h expected CAFEF00D", io_bus);
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_deselect();
        other_en = 1'b1; other_val = 32'hA5A5_5A5A;
        cs = 1'b0; rd = 1'b1; Addr = 32'h0000_03F0;
        #1;
        total++;
        if (io_bus !== 32'hA5A5_5A5A) begin
            bad++;
            $display("FAIL release_cs0: bus=%h expected A5A55A5A", io_bus);
        end
        cs = 1'b1; rd = 1'b0;
        #1;
        total++;
        if (io_bus !== 32'hA5A5_5A5A) begin
            bad++;
            $display("FAIL release_rd0: bus=%h expected A5A55A5A", io_bus);
        end
        // Write with cs low must not land.
        cs = 1'b0; wr = 1'b1; IO_In = 32'h0102_0304;
        step();
        wr = 1'b0; other_en = 1'b0;
        cs = 1'b1; rd = 1'b1;
        #1;
        total++;
        if (io_bus !== model_word(12'h3F0)) begin
            bad++;
            $display("FAIL write_cs0: got %h expected %h", io_bus, model_word(12'h3F0));
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_wrap();
        bus_write(32'h0000_0FFE, 32'h1122_3344);
        total++;
        if ({dut.Mem[12'hFFE], dut.Mem[12'hFFF], dut.Mem[12'h000], dut.Mem[12'h001]} !== 32'h1122_3344) begin
            bad++;
            $display("FAIL wrap_bytes: got %h%h%h%h expected 11223344",
                     dut.Mem[12'hFFE], dut.Mem[12'hFFF], dut.Mem[12'h000], dut.Mem[12'h001]);
        end
        cs = 1'b1; rd = 1'b1; Addr = 32'h0100_0FFE;
        #1;
        total++;
        if (io_bus !== 32'h1122_3344) begin
            bad++;
            $display("FAIL wrap_read: got %h expected 11223344", io_bus);
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_random();
        int base, off, a, op;
        logic [31:0] hi, data;
        // Fill both windows so every byte a read can touch is known.
        for (int w = 0; w < 6; w++) begin
            bus_write(32'h7F0 + 4*w, $urandom);
            bus_write((32'hFF8 + 4*w) & 32'hFFF, $urandom);
        end
        for (int i = 0; i < 150; i++) begin
            base = ($urandom_range(0, 1) == 0) ? 'h7F0 : 'hFF8;
            off  = $urandom_range(0, 15);
            a    = (base + off) % 4096;
            hi   = $urandom;
            op   = $urandom_range(0, 2);
            data = $urandom;
            if (op == 0) begin
                bus_write({hi[19:0], 12'(a)}, data);
            end else if (op == 1) begin
                cs = 1'b1; rd = 1'b1; Addr = {hi[19:0], 12'(a)};
                #1;
                total++;
                if (io_bus !== model_word(a)) begin
                    bad++;
                    $display("FAIL rand_read: addr %h got %h expected %h", Addr, io_bus, model_word(a));
                end
                step();
                cs = 1'b0; rd = 1'b0;
            end else begin
                other_en = 1'b1; other_val = data;
                cs = 1'b0; rd = 1'b1; Addr = {hi[19:0], 12'(a)};
                #1;
                total++;
                if (io_bus !== data) begin
                    bad++;
                    $display("FAIL rand_release: bus %h expected %h", io_bus, data);
                end
                step();
                other_en = 1'b0; rd = 1'b0;
            end
            total++;
            if (int_r !== m_pend) begin
                bad++;
                $display("FAIL rand_int: int_r=%b expected %b", int_r, m_pend);
            end
        end
    endtask

    task automatic test_intr_ack();
        int n;
        if (int_r !== 1'b1) begin
            cycles_to_rise(n);
            total++;
            if (n < 0) begin
                bad++;
                $display("FAIL ack_wait: int_r never rose");
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (int_r !== 1'b1) begin
                bad++;
                $display("FAIL pend_hold: int_r=%b expected 1", int_r);
            end
        end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        total++;
        if (int_r !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear: int_r=%b expected 0", int_r);
        end
        // Acks while idle must not disturb the period.
        for (int i = 1; i <= PERIOD; i++) begin
            int_ack = (i == 3 || i == 6) ? 1'b1 : 1'b0;
            step();
            int_ack = 1'b0;
            total++;
            if (int_r !== (i == PERIOD) || int_r !== m_pend) begin
                bad++;
                $display("FAIL ack_period: edge %0d int_r=%b expected %b", i, int_r, i == PERIOD);
            end
        end
        // Clear again, then ack exactly on the edge the request rises.
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        for (int i = 1; i < PERIOD; i++) step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        total++;
        if (int_r !== 1'b1) begin
            bad++;
            $display("FAIL ack_at_rise: int_r=%b expected 1", int_r);
        end
        step();
        total++;
        if (int_r !== 1'b1) begin
            bad++;
            $display("FAIL ack_at_rise_hold: int_r=%b expected 1", int_r);
        end
    endtask

    task automatic test_reset_pend();
        int n;
        if (int_r !== 1'b1) begin
            cycles_to_rise(n);
        end
        total++;
        if (int_r !== 1'b1) begin
            bad++;
            $display("FAIL rstp_setup: int_r=%b expected 1", int_r);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (int_r !== 1'b0) begin
            bad++;
            $display("FAIL rstp_async: int_r=%b expected 0", int_r);
        end
        step();
        reset = 1'b1;
        cycles_to_rise(n);
        total++;
        if (n != PERIOD) begin
            bad++;
            $display("FAIL rstp_period: rose after %0d edges expected %0d", n, PERIOD);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_deselect();
        test_wrap();
        test_random();
        test_intr_ack();
        test_reset_pend();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_io_memory

// File: doc/io_memory.md
Name: io_memory

Overview:
- 4 KB byte-addressable, big-endian memory-mapped I/O space for the MIPS CPU.
- Shares the 32-bit data-return bus with the data memory, so it drives that bus only while selected for a read.
- Contains a periodic interrupt source: it raises an interrupt request toward the CPU and clears it on the CPU's acknowledge, which exercises the interrupt service and return-from-interrupt path.

Parameters:
- INTR_PERIOD, 200, clock cycles from reset (or from the last acknowledge) until int_r asserts; legal range ≥ 2.
- INTR_ENABLE, 1, 1 enables the interrupt generator; 0 holds int_r low permanently.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select.
- wr  in  1  write enable; qualified by cs.
- rd  in  1  read enable; qualified by cs.
- int_ack  in  1  interrupt acknowledge from the CPU.
- Addr  in  32  byte address; only Addr[11:0] is used.
- IO_In  in  32  write data.
- int_r  out  1  interrupt request to the CPU.
- IO_Out  out  32  read data; tri-state shared bus.

Behaviour:
- Storage:
  - Array named Mem, declared reg [7:0] Mem[0:4095], so the bench can preload it with $readmemh.
  - Storage is not cleared by reset.
- Addressing:
  - a = Addr[11:0]. Addr[31:12] is ignored.
  - Byte k of a word is at (a+k) mod 4096, so accesses wrap at the top of the space.
  - Misaligned addresses are permitted; there is no alignment check.
- Read (combinational, zero latency):
  - When cs & rd: IO_Out = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]} (big-endian).
  - Otherwise: IO_Out = 32'hz.
  - Reset does not affect read data.
- Write (synchronous): on a rising clk with cs & wr:
  - Mem[a]   ← IO_In[31:24]
  - Mem[a+1] ← IO_In[23:16]
  - Mem[a+2] ← IO_In[15:8]
  - Mem[a+3] ← IO_In[7:0]
  - No write occurs when cs=0.
- Simultaneous rd & wr: the read shows pre-edge contents; the write commits at the edge.
- Interrupt generator (registered, two states):
  - IDLE:
    - cnt increments each clock.
    - When cnt == INTR_PERIOD-1: go to PEND, set int_r=1, cnt←0.
  - PEND:
    - int_r holds 1 and cnt holds.
    - On a rising clk with int_ack=1: go to IDLE, int_r←0, counting restarts from 0.
  - int_ack while in IDLE is ignored.
  - An ack exactly at the cycle int_r asserts has no effect; only an ack sampled while int_r=1 clears it.
  - int_r remains asserted indefinitely until acknowledged; requests do not stack.
  - INTR_ENABLE=0: int_r=0 always and cnt is held at 0.
- Reset (asynchronous, reset=0):
  - state=IDLE, cnt=0, int_r=0.
  - A pending request is discarded.
  - After reset deasserts, the first int_r rises exactly INTR_PERIOD rising edges later.
- Counter width: $clog2(INTR_PERIOD) bits, minimum 1.

Decomposition:
- Shared package: constants for the memory size (4096) and data width (32), plus a two-value state enum (IDLE, PEND) for the interrupt generator.
- One natural sub-module, io_intr_gen, holding the counter/FSM.
- The byte array and bus logic stay in io_memory.

Test Plan:
- Reset held low, then released with INTR_PERIOD=10 → int_r=0 during reset; int_r rises on the 10th rising edge after release.
- Write 0xDEADBEEF to Addr 0x3F0 → Mem[0x3F0..0x3F3] = DE AD BE EF; a read of 0x3F0 returns 0xDEADBEEF in the same cycle.
- Read with cs=0, and with cs=1 and rd=0 → IO_Out is 32'hz; a write with cs=0 leaves Mem unchanged.
- Write 0x11223344 at Addr 0xFFE → Mem[0xFFE]=11, Mem[0xFFF]=22, Mem[0x000]=33, Mem[0x001]=44; a read of 0x1000FFE returns 0x11223344.
- int_r high for 5 cycles, then a 1-cycle int_ack → int_r low after that edge and high again INTR_PERIOD edges later; int_ack pulses while int_r=0 change nothing.
- reset pulsed low while int_r=1 → int_r drops immediately (asynchronously), and the next request comes a full INTR_PERIOD after release.
